iecdrv_sd_arb: RTL and testbench

- Arbitrates up to NUM_CH drive-side SD sector request interfaces onto the single host SD block port, all in the clk_sys domain.
- Each channel looks exactly like a single-drive SD port: lba, rd, wr, ack, buff_addr, buff_dout, buff_din, buff_wr.
- Lets several drive instances (any mix of drive types) share one host image slot.
- Grants are round-robin and fair, with a per-transfer timeout and cancel handling.

---
 rtl/iecdrv_sd_arb.sv | 151 +++++++++++++++
 tb/tb_iecdrv_sd_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iecdrv_sd_arb.sv
// Round-robin arbiter sharing one host SD block port among NUM_CH drive channels.
// One transfer is in flight at a time, with cancel and ack-timeout handling.
module iecdrv_sd_arb #(
    parameter int NUM_CH  = 4,
    parameter int LBA_W   = 32,
    parameter int TIMEOUT = 1048576
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [NUM_CH*LBA_W-1:0]   ch_lba,
    input  logic [NUM_CH-1:0]         ch_rd,
    input  logic [NUM_CH-1:0]         ch_wr,
    output logic [NUM_CH-1:0]         ch_ack,
    input  logic [NUM_CH*8-1:0]       ch_buff_din,
    output logic [NUM_CH-1:0]         ch_buff_wr,
    output logic [8:0]                ch_buff_addr,
    output logic [7:0]                ch_buff_dout,
    output logic [LBA_W-1:0]          sd_lba,
    output logic                      sd_rd,
    output logic                      sd_wr,
    input  logic                      sd_ack,
    input  logic [8:0]                sd_buff_addr,
    input  logic [7:0]                sd_buff_dout,
    output logic [7:0]                sd_buff_din,
    input  logic                      sd_buff_wr,
    output logic                      busy,
    output logic [2:0]                grant,
    output logic                      timeout
);

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t             state, state_nx;
    logic [2:0]         rr, rr_nx;
    logic [CNT_W-1:0]   wait_cnt;
    logic [NUM_CH-1:0]  req;
    logic               hit, pick_rd, gnt_req, tmo_hit, active;
    logic [2:0]         pick;
    logic [LBA_W-1:0]   pick_lba;
    int                 j;

    assign req          = ch_rd | ch_wr;
    assign active       = (state == REQ) || (state == XFER);
    assign busy         = (state != IDLE);
    assign ch_buff_addr = sd_buff_addr;
    assign ch_buff_dout = sd_buff_dout;
    assign tmo_hit      = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign rr_nx        = (grant == 3'(NUM_CH - 1)) ? 3'd0 : grant + 3'd1;

    // Walk the offsets from the far end so the nearest requester to rr wins.
    always_comb begin
        hit      = 1'b0;
        pick     = 3'd0;
        pick_rd  = 1'b0;
        pick_lba = '0;
        j        = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = int'(rr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            for (int i = 0; i < NUM_CH; i++) begin
                if (i == j && req[i]) begin
                    hit  = 1'b1;
                    pick = 3'(i);
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick == 3'(i)) begin
                pick_rd  = ch_rd[i];
                pick_lba = ch_lba[i*LBA_W +: LBA_W];
            end
        end
    end

    // Only the granted channel sees the host handshake, and only while a transfer is live.
    always_comb begin
        gnt_req     = 1'b0;
        sd_buff_din = '0;
        ch_ack      = '0;
        ch_buff_wr  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == 3'(i)) begin
                gnt_req = req[i];
                if (active) begin
                    sd_buff_din   = ch_buff_din[i*8 +: 8];
                    ch_ack[i]     = sd_ack;
                    ch_buff_wr[i] = sd_buff_wr;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (hit) state_nx = REQ;
            REQ: begin
                if (sd_ack)        state_nx = XFER;
                else if (!gnt_req) state_nx = IDLE;
                else if (tmo_hit)  state_nx = IDLE;
            end
            XFER: if (!sd_ack) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            rr       <= 3'd0;
            grant    <= 3'd0;
            sd_lba   <= '0;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state   <= state_nx;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        grant    <= pick;
                        sd_lba   <= pick_lba;
                        sd_rd    <= pick_rd;
                        sd_wr    <= ~pick_rd;
                        wait_cnt <= '0;
                    end
                end
                REQ: begin
                    if (wait_cnt != '1) wait_cnt <= wait_cnt + CNT_W'(1);
                    if (state_nx != REQ) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                    end
                    // A cancel leaves rr alone; a timeout moves past the stuck channel.
                    if (!sd_ack && gnt_req && tmo_hit) begin
                        timeout <= 1'b1;
                        rr      <= rr_nx;
                    end
                end
                DONE: rr <= rr_nx;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iecdrv_sd_arb.sv
// Scoreboard bench for iecdrv_sd_arb: expected grants are queued as requests are
// raised and checked when the host side sees each request.
module tb_iecdrv_sd_arb;

    localparam int NCH = 4;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic [NCH*32-1:0] ch_lba;
    logic [NCH-1:0]    ch_rd, ch_wr, ch_ack, ch_buff_wr;
    logic [NCH*8-1:0]  ch_buff_din;
    logic [8:0]        ch_buff_addr, sd_buff_addr;
    logic [7:0]        ch_buff_dout, sd_buff_dout, sd_buff_din;
    logic [31:0]       sd_lba;
    logic              sd_rd, sd_wr, sd_ack, sd_buff_wr, busy, timeout;
    logic [2:0]        grant;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] lba;
        bit          rd;
        logic [7:0]  din;
    } exp_t;
    exp_t q[$];

    iecdrv_sd_arb #(.NUM_CH(NCH), .LBA_W(32), .TIMEOUT(16)) dut (
        .clk_sys(clk_sys), .reset(reset), .ch_lba(ch_lba), .ch_rd(ch_rd), .ch_wr(ch_wr),
        .ch_ack(ch_ack), .ch_buff_din(ch_buff_din), .ch_buff_wr(ch_buff_wr),
        .ch_buff_addr(ch_buff_addr), .ch_buff_dout(ch_buff_dout), .sd_lba(sd_lba),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
        .busy(busy), .grant(grant), .timeout(timeout)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic push(input int ch, input bit rd);
        exp_t e;
        e.ch  = 3'(ch);
        e.lba = ch_lba[ch*32 +: 32];
        e.rd  = rd;
        e.din = ch_buff_din[ch*8 +: 8];
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1; ch_rd = '0; ch_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        sd_buff_addr = '0; sd_buff_dout = '0;
        step(); step();
        reset = 1'b0;
        q.delete();
    endtask

    // Wait for a host request, check it against the queue head, then run the handshake.
    task automatic serve(input int lat, input int hold, input bit drop);
        exp_t e;
        bit   ok = 0;
        logic [NCH-1:0] one;
        for (int c = 0; c < 64 && !ok; c++) begin
            if (sd_rd | sd_wr) ok = 1;
            else step();
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL serve_wait no host request within 64 cycles"); return; end
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL serve_queue unexpected request grant=%0d", grant); return; end
        e = q.pop_front();
        one = NCH'(1) << e.ch;
        checks++;
        if (grant !== e.ch) begin failures++; $display("FAIL grant got=%0d exp=%0d", grant, e.ch); end
        checks++;
        if (sd_lba !== e.lba) begin failures++; $display("FAIL sd_lba got=%h exp=%h", sd_lba, e.lba); end
        checks++;
        if (sd_rd !== e.rd || sd_wr !== !e.rd || busy !== 1'b1) begin
            failures++; $display("FAIL req_lines rd=%b wr=%b busy=%b exp_rd=%b", sd_rd, sd_wr, busy, e.rd);
        end
        repeat (lat) begin
            step();
            checks++;
            if (ch_ack !== '0 || (sd_rd | sd_wr) !== 1'b1) begin
                failures++; $display("FAIL pre_ack ch_ack=%b rd=%b wr=%b", ch_ack, sd_rd, sd_wr);
            end
        end
        sd_ack = 1'b1;
        if (drop) begin
            if (e.rd) ch_rd[e.ch] = 1'b0;
            else      ch_wr[e.ch] = 1'b0;
        end
        #1;
        checks++;
        if (ch_ack !== one) begin failures++; $display("FAIL ack_rise ch_ack=%b exp=%b", ch_ack, one); end
        for (int h = 0; h < hold; h++) begin
            step();
            sd_buff_wr   = h[0];
            sd_buff_addr = 9'(h + 3);
            sd_buff_dout = 8'($urandom_range(0, 255));
            #1;
            checks++;
            if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
                failures++; $display("FAIL xfer_req rd=%b wr=%b exp 0", sd_rd, sd_wr);
            end
            checks++;
            if (ch_ack !== one || ch_buff_wr !== (h[0] ? one : '0)) begin
                failures++; $display("FAIL xfer_strobes ch_ack=%b ch_buff_wr=%b exp_ack=%b", ch_ack, ch_buff_wr, one);
            end
            checks++;
            if (ch_buff_addr !== sd_buff_addr || ch_buff_dout !== sd_buff_dout) begin
                failures++; $display("FAIL passthru addr=%h dout=%h exp %h %h", ch_buff_addr, ch_buff_dout, sd_buff_addr, sd_buff_dout);
            end
            if (!e.rd) begin
                checks++;
                if (sd_buff_din !== e.din) begin failures++; $display("FAIL sd_buff_din got=%h exp=%h", sd_buff_din, e.din); end
            end
        end
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        #1;
        checks++;
        if (ch_ack !== '0 || ch_buff_wr !== '0) begin failures++; $display("FAIL ack_fall ch_ack=%b buff_wr=%b", ch_ack, ch_buff_wr); end
        step();
        checks++;
        if (busy !== 1'b1 || ch_ack !== '0) begin failures++; $display("FAIL done_cycle busy=%b ch_ack=%b", busy, ch_ack); end
    endtask

    task automatic test_reset();
        ch_lba      = {32'h0000_00DD, 32'h0000_0123, 32'h0000_00BB, 32'h0000_00AA};
        ch_buff_din = {8'h3C, 8'h5A, 8'hA5, 8'h11};
        do_reset();
        checks++;
        if ({sd_rd, sd_wr, busy, timeout} !== 4'b0 || grant !== 3'd0 || sd_lba !== '0) begin
            failures++; $display("FAIL reset_ctrl rd=%b wr=%b busy=%b tmo=%b grant=%0d lba=%h", sd_rd, sd_wr, busy, timeout, grant, sd_lba);
        end
        checks++;
        if (ch_ack !== '0 || ch_buff_wr !== '0 || sd_buff_din !== '0) begin
            failures++; $display("FAIL reset_data ch_ack=%b buff_wr=%b din=%h", ch_ack, ch_buff_wr, sd_buff_din);
        end
    endtask

    task automatic test_single();
        do_reset();
        ch_rd = 4'b0100;
        push(2, 1);
        step();
        checks++;
        if (sd_rd !== 1'b1) begin failures++; $display("FAIL single_latency sd_rd=%b exp 1", sd_rd); end
        serve(3, 3, 1);
        // rr must now be 3: ch3 goes before ch0
        ch_rd = 4'b1001;
        push(3, 1); push(0, 1);
        serve(1, 2, 1);
        serve(1, 2, 1);
    endtask

    task automatic test_fairness();
        do_reset();
        ch_rd = 4'b1111;
        push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(0, 1);
        repeat (5) serve(1, 2, 0);
        ch_rd = '0;
        step(); step();
    endtask

    task automatic test_write();
        do_reset();
        ch_wr = 4'b0010;
        push(1, 0);
        serve(2, 4, 1);
        step(); step();
    endtask

    task automatic test_rdwr();
        do_reset();
        ch_rd = 4'b1001; ch_wr = 4'b0001;
        push(0, 1); push(3, 1); push(0, 0);
        repeat (3) serve(1, 2, 1);
        step(); step();
    endtask

    task automatic test_timeout();
        bit ok = 0;
        do_reset();
        ch_rd = 4'b0100;
        for (int c = 0; c < 8 && !ok; c++) begin
            if (sd_rd) ok = 1;
            else step();
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL tmo_req sd_rd never rose"); end
        for (int c = 1; c < 16; c++) begin
            step();
            checks++;
            if (timeout !== 1'b0 || sd_rd !== 1'b1) begin
                failures++; $display("FAIL tmo_early cycle=%0d timeout=%b sd_rd=%b", c, timeout, sd_rd);
            end
        end
        step();
        checks++;
        if (timeout !== 1'b1 || sd_rd !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL tmo_pulse timeout=%b sd_rd=%b busy=%b exp 1 0 0", timeout, sd_rd, busy);
        end
        ch_rd = 4'b1101;
        step();
        checks++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL tmo_width timeout=%b exp 0", timeout); end
        // rr advanced past ch2
        push(3, 1); push(0, 1); push(2, 1);
        repeat (3) serve(0, 1, 1);
        step(); step();
    endtask

    task automatic test_cancel();
        bit ok = 0;
        do_reset();
        ch_rd = 4'b0010;
        for (int c = 0; c < 8 && !ok; c++) begin
            if (sd_rd) ok = 1;
            else step();
        end
        ch_rd = '0;
        step();
        checks++;
        if (!ok || sd_rd !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL cancel seen=%b sd_rd=%b busy=%b exp 1 0 0", ok, sd_rd, busy);
        end
        // rr still 0: ch1 before ch3
        ch_rd = 4'b1010;
        push(1, 1); push(3, 1);
        repeat (2) serve(1, 1, 1);
        step(); step();
    endtask

    task automatic test_reset_xfer();
        do_reset();
        ch_rd = 4'b0100;
        push(2, 1);
        step();
        checks++;
        if (sd_rd !== 1'b1) begin failures++; $display("FAIL rx_req sd_rd=%b exp 1", sd_rd); end
        sd_ack = 1'b1;
        step();
        #1;
        checks++;
        if (ch_ack !== 4'b0100) begin failures++; $display("FAIL rx_xfer ch_ack=%b exp 0100", ch_ack); end
        reset = 1'b1; ch_rd = '0;
        step();
        checks++;
        if ({sd_rd, sd_wr, busy, timeout} !== 4'b0 || grant !== 3'd0 || ch_ack !== '0 || sd_lba !== '0) begin
            failures++; $display("FAIL rx_reset rd=%b wr=%b busy=%b grant=%0d ch_ack=%b lba=%h", sd_rd, sd_wr, busy, grant, ch_ack, sd_lba);
        end
        reset = 1'b0;
        step();
        checks++;
        if (ch_ack !== '0 || busy !== 1'b0) begin failures++; $display("FAIL idle_ack ch_ack=%b busy=%b exp 0 0", ch_ack, busy); end
        sd_ack = 1'b0;
        q.delete();
    endtask

    initial begin
        reset = 1'b1; ch_rd = '0; ch_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        sd_buff_addr = '0; sd_buff_dout = '0; ch_lba = '0; ch_buff_din = '0;
        test_reset();
        test_single();
        test_fairness();
        test_write();
        test_rdwr();
        test_timeout();
        test_cancel();
        test_reset_xfer();
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL leftover queue size=%0d exp 0", q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
